gray_frame_ctrl: RTL and testbench

GRAY_FRAME_CTRL -- requirements
Module: gray_frame_ctrl

---
 rtl/gray_frame_ctrl_if.sv | 44 ++++
 rtl/gray_frame_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_gray_frame_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gray_frame_ctrl_if.sv
// rtl/gray_frame_ctrl_if.sv - video/config bundle for gray_frame_ctrl
//
// Purpose: groups the input video timing and pixel signals, the config
// handshake and the delayed video and status outputs of gray_frame_ctrl.
// Modports:
//   slave  - seen by gray_frame_ctrl (drives the o_* signals)
//   master - seen by the source/sink (drives the i_* signals)
// Signals:
//   i_VDE, i_HSYNC, i_VSYNC    input timing (active high)
//   i_pixelData[23:0]          input pixel, [23:16]=R [15:8]=B [7:0]=G
//   i_cfgValid, i_cfgMode[1:0] config request
//   o_cfgReady                 config request can be accepted
//   o_VDE, o_HSYNC, o_VSYNC    timing delayed by two clocks
//   o_pixelData[23:0]          processed pixel, same byte order
//   o_frameCnt[15:0]           frames started
//   o_lineErr, o_frameErr      one-cycle geometry error pulses
interface gray_frame_ctrl_if;
  logic        i_VDE;
  logic        i_HSYNC;
  logic        i_VSYNC;
  logic [23:0] i_pixelData;
  logic        i_cfgValid;
  logic [1:0]  i_cfgMode;
  logic        o_cfgReady;
  logic        o_VDE;
  logic        o_HSYNC;
  logic        o_VSYNC;
  logic [23:0] o_pixelData;
  logic [15:0] o_frameCnt;
  logic        o_lineErr;
  logic        o_frameErr;

  modport slave (
    input  i_VDE, i_HSYNC, i_VSYNC, i_pixelData, i_cfgValid, i_cfgMode,
    output o_cfgReady, o_VDE, o_HSYNC, o_VSYNC, o_pixelData, o_frameCnt,
           o_lineErr, o_frameErr
  );

  modport master (
    output i_VDE, i_HSYNC, i_VSYNC, i_pixelData, i_cfgValid, i_cfgMode,
    input  o_cfgReady, o_VDE, o_HSYNC, o_VSYNC, o_pixelData, o_frameCnt,
           o_lineErr, o_frameErr
  );
endinterface

// File: rtl/gray_frame_ctrl.sv
// rtl/gray_frame_ctrl.sv - frame-synchronous grayscale converter with geometry checks
//
// Purpose: passes a video stream through a two-stage pipeline, optionally
// converting active pixels to gray (average or luma). The processing mode is
// requested through a valid/ready handshake and only takes effect at a frame
// start (VSYNC rising edge). Line length and frame height are checked against
// H_ACTIVE / V_ACTIVE once the first frame start has been seen.
// Parameters:
//   H_ACTIVE  expected active pixels per line
//   V_ACTIVE  expected active lines per frame
// Ports:
//   i_clk   pixel clock, the only clock
//   i_rstn  asynchronous active-low reset
//   bus     gray_frame_ctrl_if.slave (video in/out, config, status)
module gray_frame_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  gray_frame_ctrl_if.slave   bus
);

  localparam logic [1:0]  MODE_BYPASS = 2'b00;
  localparam logic [1:0]  MODE_AVG    = 2'b01;
  localparam logic [1:0]  MODE_LUMA   = 2'b10;
  localparam logic [10:0] LP_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [9:0]  LP_V_ACTIVE = 10'(V_ACTIVE);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_run;
  logic        w_line_err_det;
  logic        w_frame_err_det;

  logic        r_vsync_d;
  logic        r_vde_d;
  logic        w_frame_start;
  logic        w_vde_fall;

  logic        r_pend_valid;
  logic [1:0]  r_pend_mode;
  logic [1:0]  r_active_mode;
  logic        w_cfg_accept;

  logic [10:0] r_pix_cnt;
  logic [9:0]  r_line_cnt;
  logic [15:0] r_frame_cnt;
  logic        r_line_err;
  logic        r_frame_err;

  // Stage 1: registered inputs, mode and sums
  logic        r_s1_vde;
  logic        r_s1_hsync;
  logic        r_s1_vsync;
  logic [23:0] r_s1_data;
  logic [1:0]  r_s1_mode;
  logic [9:0]  r_s1_avg_sum;
  logic [15:0] r_s1_luma_sum;

  // Stage 2: registered result
  logic        r_s2_vde;
  logic        r_s2_hsync;
  logic        r_s2_vsync;
  logic [23:0] r_s2_data;

  logic [7:0]  w_r;
  logic [7:0]  w_b;
  logic [7:0]  w_g;
  logic [9:0]  w_avg_sum;
  logic [15:0] w_luma_sum;
  logic [7:0]  w_avg;
  logic [7:0]  w_luma;
  logic [23:0] w_s2_data_nxt;

  // Edge detection against registered copies of the timing inputs
  assign w_frame_start = bus.i_VSYNC & ~r_vsync_d;
  assign w_vde_fall    = ~bus.i_VDE & r_vde_d;

  // Ready is simply "nothing pending"; a pending request blocks new ones
  assign w_cfg_accept  = bus.i_cfgValid & ~r_pend_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_run           = 1'b0;
    w_line_err_det  = 1'b0;
    w_frame_err_det = 1'b0;
    case (r_state)
      WAIT_SYNC: begin
        if (w_frame_start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_run           = 1'b1;
        w_line_err_det  = w_vde_fall & (r_pix_cnt != LP_H_ACTIVE);
        // The first frame start happens in WAIT_SYNC, so it never flags
        w_frame_err_det = w_frame_start & (r_line_cnt != LP_V_ACTIVE);
      end
      default: begin
        w_state_nxt = WAIT_SYNC;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vsync_d <= 1'b0;
      r_vde_d   <= 1'b0;
    end else begin
      r_vsync_d <= bus.i_VSYNC;
      r_vde_d   <= bus.i_VDE;
    end
  end

  // A request accepted in the frame-start cycle lands in the pending register
  // after the apply decision, so it waits for the following frame start.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pend_valid  <= 1'b0;
      r_pend_mode   <= MODE_BYPASS;
      r_active_mode <= MODE_BYPASS;
    end else if (w_frame_start && r_pend_valid) begin
      r_active_mode <= r_pend_mode;
      r_pend_valid  <= 1'b0;
    end else if (w_cfg_accept) begin
      r_pend_mode  <= bus.i_cfgMode;
      r_pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_frame_cnt <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (bus.i_VDE) begin
        r_pix_cnt <= r_pix_cnt + 11'd1;
      end else if (w_vde_fall) begin
        r_pix_cnt <= '0;
      end

      if (w_frame_start) begin
        r_line_cnt <= '0;
      end else if (w_vde_fall) begin
        r_line_cnt <= r_line_cnt + 10'd1;
      end

      if (w_frame_start) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_line_err  <= w_line_err_det;
      r_frame_err <= w_frame_err_det;
    end
  end

  assign w_r        = bus.i_pixelData[23:16];
  assign w_b        = bus.i_pixelData[15:8];
  assign w_g        = bus.i_pixelData[7:0];
  assign w_avg_sum  = {2'b00, w_r} + {2'b00, w_g} + {2'b00, w_b};
  assign w_luma_sum = (16'd77  * {8'd0, w_r})
                    + (16'd150 * {8'd0, w_g})
                    + (16'd29  * {8'd0, w_b});

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1_vde      <= 1'b0;
      r_s1_hsync    <= 1'b0;
      r_s1_vsync    <= 1'b0;
      r_s1_data     <= '0;
      r_s1_mode     <= MODE_BYPASS;
      r_s1_avg_sum  <= '0;
      r_s1_luma_sum <= '0;
    end else begin
      r_s1_vde      <= bus.i_VDE;
      r_s1_hsync    <= bus.i_HSYNC;
      r_s1_vsync    <= bus.i_VSYNC;
      r_s1_data     <= bus.i_pixelData;
      r_s1_mode     <= w_run ? r_active_mode : MODE_BYPASS;
      r_s1_avg_sum  <= w_avg_sum;
      r_s1_luma_sum <= w_luma_sum;
    end
  end

  // Coefficients sum to 256, so the shifted luma never exceeds 255
  assign w_avg  = 8'(r_s1_avg_sum / 10'd3);
  assign w_luma = 8'(r_s1_luma_sum >> 8);

  always_comb begin
    w_s2_data_nxt = r_s1_data;
    if (r_s1_vde) begin
      case (r_s1_mode)
        MODE_AVG:  w_s2_data_nxt = {w_avg, w_avg, w_avg};
        MODE_LUMA: w_s2_data_nxt = {w_luma, w_luma, w_luma};
        default:   w_s2_data_nxt = r_s1_data;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s2_vde   <= 1'b0;
      r_s2_hsync <= 1'b0;
      r_s2_vsync <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_s2_vde   <= r_s1_vde;
      r_s2_hsync <= r_s1_hsync;
      r_s2_vsync <= r_s1_vsync;
      r_s2_data  <= w_s2_data_nxt;
    end
  end

  assign bus.o_cfgReady  = ~r_pend_valid;
  assign bus.o_VDE       = r_s2_vde;
  assign bus.o_HSYNC     = r_s2_hsync;
  assign bus.o_VSYNC     = r_s2_vsync;
  assign bus.o_pixelData = r_s2_data;
  assign bus.o_frameCnt  = r_frame_cnt;
  assign bus.o_lineErr   = r_line_err;
  assign bus.o_frameErr  = r_frame_err;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// tb/tb_gray_frame_ctrl.sv - directed self-checking bench for gray_frame_ctrl
module tb_gray_frame_ctrl;
  localparam int H = 8;
  localparam int V = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gray_frame_ctrl_if bus ();

  gray_frame_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_req(input logic [1:0] mode);
    bus.i_cfgValid = 1'b1;
    bus.i_cfgMode  = mode;
    tick();
    bus.i_cfgValid = 1'b0;
  endtask

  task automatic drive_line(input logic [23:0] pix, input int n,
                            input logic [23:0] exp, input logic lerr);
    for (int i = 0; i < n; i++) begin
      bus.i_VDE       = 1'b1;
      bus.i_pixelData = pix;
      tick();
      if (i >= 1) begin
        chk("line_data", bus.o_pixelData, exp);
        chk("line_vde", bus.o_VDE, 1);
      end
    end
    bus.i_VDE       = 1'b0;
    bus.i_pixelData = 24'h0;
    bus.i_HSYNC     = 1'b1;
    tick();
    chk("line_last_data", bus.o_pixelData, exp);
    chk("line_err", bus.o_lineErr, lerr);
    tick();
    chk("line_err_once", bus.o_lineErr, 0);
    chk("blank_vde", bus.o_VDE, 0);
    chk("blank_hsync", bus.o_HSYNC, 1);
    chk("blank_data", bus.o_pixelData, 0);
    bus.i_HSYNC = 1'b0;
    tick();
    tick();
  endtask

  task automatic vsync_frame(input logic ferr, input logic [15:0] fcnt);
    bus.i_VSYNC = 1'b1;
    tick();
    chk("frame_err", bus.o_frameErr, ferr);
    chk("frame_cnt", bus.o_frameCnt, fcnt);
    bus.i_VSYNC = 1'b0;
    tick();
    chk("vsync_delayed", bus.o_VSYNC, 1);
    chk("frame_err_once", bus.o_frameErr, 0);
    tick();
    chk("vsync_low", bus.o_VSYNC, 0);
  endtask

  initial begin
    bus.i_VDE       = 1'b0;
    bus.i_HSYNC     = 1'b0;
    bus.i_VSYNC     = 1'b0;
    bus.i_pixelData = 24'h0;
    bus.i_cfgValid  = 1'b0;
    bus.i_cfgMode   = 2'b00;

    // Reset state
    repeat (3) tick();
    chk("rst_pix", bus.o_pixelData, 0);
    chk("rst_vde", bus.o_VDE, 0);
    chk("rst_hsync", bus.o_HSYNC, 0);
    chk("rst_vsync", bus.o_VSYNC, 0);
    chk("rst_fcnt", bus.o_frameCnt, 0);
    chk("rst_lerr", bus.o_lineErr, 0);
    chk("rst_ferr", bus.o_frameErr, 0);
    chk("rst_ready", bus.o_cfgReady, 1);
    rstn = 1'b1;
    tick();
    tick();

    // Frame 1: bypass; mode 01 requested mid-frame stays pending
    vsync_frame(1'b0, 16'd1);
    drive_line(24'h102030, H, 24'h102030, 1'b0);
    cfg_req(2'b01);
    chk("cfg_ready_low", bus.o_cfgReady, 0);
    repeat (V - 1) drive_line(24'h302010, H, 24'h302010, 1'b0);
    chk("cfg_ready_held", bus.o_cfgReady, 0);

    // Frame 2: average mode, one short line, only 3 lines
    vsync_frame(1'b0, 16'd2);
    chk("cfg_ready_back", bus.o_cfgReady, 1);
    drive_line(24'h302010, H, 24'h202020, 1'b0);
    drive_line(24'h302010, H - 1, 24'h202020, 1'b1);
    drive_line(24'h302010, H, 24'h202020, 1'b0);

    // Frame 3 start: request in the VSYNC rise cycle, then an ignored one
    bus.i_cfgValid = 1'b1;
    bus.i_cfgMode  = 2'b10;
    bus.i_VSYNC    = 1'b1;
    tick();
    chk("short_frame_err", bus.o_frameErr, 1);
    chk("frame_cnt_3", bus.o_frameCnt, 3);
    bus.i_cfgMode = 2'b01;
    bus.i_VSYNC   = 1'b0;
    tick();
    chk("same_cycle_pending", bus.o_cfgReady, 0);
    chk("short_frame_err_once", bus.o_frameErr, 0);
    bus.i_cfgValid = 1'b0;
    tick();
    repeat (V) drive_line(24'h302010, H, 24'h202020, 1'b0);
    chk("cfg_ready_f3", bus.o_cfgReady, 0);

    // Frame 4: luma (the 01 request was ignored)
    vsync_frame(1'b0, 16'd4);
    chk("cfg_ready_f4", bus.o_cfgReady, 1);
    drive_line(24'hFFFFFF, H, 24'hFFFFFF, 1'b0);
    drive_line(24'hFF0000, H, 24'h4C4C4C, 1'b0);
    drive_line(24'h302010, H, 24'h1B1B1B, 1'b0);
    drive_line(24'h000000, H, 24'h000000, 1'b0);

    // Mid-frame reset with a pending request
    cfg_req(2'b01);
    chk("pend_before_rst", bus.o_cfgReady, 0);
    bus.i_VDE       = 1'b1;
    bus.i_pixelData = 24'hFF0000;
    tick();
    tick();
    tick();
    chk("pre_rst_pix", bus.o_pixelData, 24'h4C4C4C);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst2_pix", bus.o_pixelData, 0);
    chk("rst2_vde", bus.o_VDE, 0);
    chk("rst2_ready", bus.o_cfgReady, 1);
    chk("rst2_fcnt", bus.o_frameCnt, 0);
    bus.i_VDE       = 1'b0;
    bus.i_pixelData = 24'h0;
    tick();
    rstn = 1'b1;
    tick();

    // Before the first frame start: bypass and no line error on a short line
    drive_line(24'h302010, H - 3, 24'h302010, 1'b0);
    vsync_frame(1'b0, 16'd1);
    drive_line(24'h302010, H, 24'h302010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
